// File: rtl/ti_quad_layer_serial_if.sv
// Handshake and share bundle between the serial quadratic layer and its
// producer/consumer. NIBBLES must match the attached ti_quad_layer_serial.
interface ti_quad_layer_serial_if #(
    parameter int NIBBLES = 16
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x1;
    logic [W-1:0] in_x2;
    logic [W-1:0] in_x3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y1;
    logic [W-1:0] out_y2;
    logic [W-1:0] out_y3;
    logic         busy;

    modport master (
        output in_valid, in_x1, in_x2, in_x3, out_ready,
        input  in_ready, out_valid, out_y1, out_y2, out_y3, busy
    );

    modport slave (
        input  in_valid, in_x1, in_x2, in_x3, out_ready,
        output in_ready, out_valid, out_y1, out_y2, out_y3, busy
    );
endinterface

// File: rtl/ti_quad_layer_serial.sv
// Nibble-serial 3-share quadratic S-box layer: one Quadratic_294 evaluated per
// cycle, results rotated back into the share registers in original order.

// 3-share threshold implementation of y = (a, b, c^ab, d^ac^bc), x = {a,b,c,d}.
// Output share k never sees input share k (non-completeness).
module Quadratic_294 (
    input  logic [3:0] x1,
    input  logic [3:0] x2,
    input  logic [3:0] x3,
    output logic [3:0] y1,
    output logic [3:0] y2,
    output logic [3:0] y3
);
    function automatic logic [3:0] q_share(input logic [3:0] p, input logic [3:0] q);
        logic t_ab;
        logic t_ac;
        logic t_bc;
        t_ab = (p[3] & p[2]) ^ (p[3] & q[2]) ^ (q[3] & p[2]);
        t_ac = (p[3] & p[1]) ^ (p[3] & q[1]) ^ (q[3] & p[1]);
        t_bc = (p[2] & p[1]) ^ (p[2] & q[1]) ^ (q[2] & p[1]);
        return {p[3], p[2], p[1] ^ t_ab, p[0] ^ t_ac ^ t_bc};
    endfunction

    assign y1 = q_share(x2, x3);
    assign y2 = q_share(x3, x1);
    assign y3 = q_share(x1, x2);
endmodule

module ti_quad_layer_serial #(
    parameter int NIBBLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ti_quad_layer_serial_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  s1_r;
    logic [W-1:0]  s2_r;
    logic [W-1:0]  s3_r;
    logic          busy_r;
    logic          out_valid_r;
    logic          load_s;
    logic          shift_s;
    logic          in_ready_s;
    logic [3:0]    y1_s;
    logic [3:0]    y2_s;
    logic [3:0]    y3_s;

    Quadratic_294 u_q294 (
        .x1 (s1_r[3:0]),
        .x2 (s2_r[3:0]),
        .x3 (s3_r[3:0]),
        .y1 (y1_s),
        .y2 (y2_s),
        .y3 (y3_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, load/shift strobes and the combinational in_ready
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                shift_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    in_ready_s = 1'b1;
                    if (bus.in_valid) begin
                        load_s     = 1'b1;
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Share registers and nibble counter; cnt stops at its terminal value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r  <= '0;
            s2_r  <= '0;
            s3_r  <= '0;
            cnt_r <= '0;
        end else if (load_s) begin
            s1_r  <= bus.in_x1;
            s2_r  <= bus.in_x2;
            s3_r  <= bus.in_x3;
            cnt_r <= '0;
        end else if (shift_s) begin
            s1_r <= {y1_s, s1_r[W-1:4]};
            s2_r <= {y2_s, s2_r[W-1:4]};
            s3_r <= {y3_s, s3_r[W-1:4]};
            if (cnt_r != CNT_LAST) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            s1_r  <= s1_r;
            s2_r  <= s2_r;
            s3_r  <= s3_r;
            cnt_r <= cnt_r;
        end
    end

    // Status flags registered from the next state so they carry no input path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            busy_r      <= (state_nx_s == ST_RUN);
            out_valid_r <= (state_nx_s == ST_DONE);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_y1    = s1_r;
    assign bus.out_y2    = s2_r;
    assign bus.out_y3    = s3_r;
endmodule

// File: tb/tb_ti_quad_layer_serial.sv
// Randomized self-checking bench for ti_quad_layer_serial against an
// unshared/shared Q294 reference built from the quadratic's algebra.
module tb_ti_quad_layer_serial;
    localparam int NIB = 16;
    localparam int W   = 4 * NIB;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ti_quad_layer_serial_if #(.NIBBLES(NIB)) bus ();

    ti_quad_layer_serial #(.NIBBLES(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unshared Q294: {a,b,c,d} -> {a, b, c^ab, d^ac^bc}
    function automatic logic [3:0] q294(input logic [3:0] x);
        logic a, b, c, d;
        {a, b, c, d} = x;
        return {a, b, c ^ (a & b), d ^ (a & c) ^ (b & c)};
    endfunction

    // Share k is f(xj^xl) ^ f(xl): linear part of xj plus all cross terms of xj,xl
    function automatic logic [3:0] q294_share(input logic [3:0] p, input logic [3:0] q);
        return q294(p ^ q) ^ q294(q);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] x1, input logic [W-1:0] x2,
                                input logic [W-1:0] x3);
        logic [W-1:0] e1, e2, e3, eg, xs;
        xs = x1 ^ x2 ^ x3;
        for (int i = 0; i < NIB; i++) begin
            e1[4*i +: 4] = q294_share(x2[4*i +: 4], x3[4*i +: 4]);
            e2[4*i +: 4] = q294_share(x3[4*i +: 4], x1[4*i +: 4]);
            e3[4*i +: 4] = q294_share(x1[4*i +: 4], x2[4*i +: 4]);
            eg[4*i +: 4] = q294(xs[4*i +: 4]);
        end
        check_eq({tag, "_y1"}, bus.out_y1, e1);
        check_eq({tag, "_y2"}, bus.out_y2, e2);
        check_eq({tag, "_y3"}, bus.out_y3, e3);
        check_eq({tag, "_unshared"}, bus.out_y1 ^ bus.out_y2 ^ bus.out_y3, eg);
    endtask

    // Called at posedge+1 while idle: present shares, take the accept edge
    task automatic start_txn(input logic [W-1:0] x1, input logic [W-1:0] x2, input logic [W-1:0] x3);
        bus.in_x1    = x1;
        bus.in_x2    = x2;
        bus.in_x3    = x3;
        bus.in_valid = 1'b1;
        check_eq("accept_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges until out_valid (bounded); optionally spray garbage during RUN
    task automatic wait_done(input bit garbage, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.out_valid && garbage) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_x1    = {$urandom, $urandom};
                bus.in_x2    = {$urandom, $urandom};
                bus.in_x3    = {$urandom, $urandom};
            end
        end while (!bus.out_valid && n < 40);
        if (garbage) bus.in_valid = 1'b0;
    endtask

    logic [W-1:0] a1, a2, a3, h1, h2, h3;
    logic [W-1:0] q1 [4];
    logic [W-1:0] q2 [4];
    logic [W-1:0] q3 [4];
    int n;
    int hits;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_x1     = '0;
        bus.in_x2     = '0;
        bus.in_x3     = '0;

        // Reset values with no clock edge seen yet
        #3;
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_y", {bus.out_y1 | bus.out_y2 | bus.out_y3}, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("idle_ready", bus.in_ready, 1);
            check_eq("idle_busy", bus.busy, 0);
        end

        // Single transaction with the fixed shares
        a1 = 64'h0123456789ABCDEF;
        a2 = 64'hFEDCBA9876543210;
        a3 = 64'h0F1E2D3C4B5A6978;
        start_txn(a1, a2, a3);
        check_eq("run_busy", bus.busy, 1);
        check_eq("run_in_ready", bus.in_ready, 0);
        wait_done(1'b0, n);
        check_eq("single_latency", n, 16);
        check_result("single", a1, a2, a3);
        @(posedge clk);
        #1;
        h1 = bus.out_y1;
        check_eq("back_to_idle", bus.out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_y_stable", bus.out_y1, h1);

        // Backpressure in DONE
        a1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom};
        a3 = {$urandom, $urandom};
        bus.out_ready = 1'b0;
        start_txn(a1, a2, a3);
        wait_done(1'b0, n);
        check_eq("bp_latency", n, 16);
        check_result("bp", a1, a2, a3);
        h1 = bus.out_y1;
        h2 = bus.out_y2;
        h3 = bus.out_y3;
        repeat (10) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold", {bus.out_y1 ^ h1} | {bus.out_y2 ^ h2} | {bus.out_y3 ^ h3}, 0);
            check_eq("bp_valid", bus.out_valid, 1);
            check_eq("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        check_eq("bp_taken", bus.out_valid, 0);

        // Back-to-back: four states, continuous valid/ready
        for (int k = 0; k < 4; k++) begin
            q1[k] = {$urandom, $urandom};
            q2[k] = {$urandom, $urandom};
            q3[k] = {$urandom, $urandom};
        end
        bus.in_x1    = q1[0];
        bus.in_x2    = q2[0];
        bus.in_x3    = q3[0];
        bus.in_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k < 3) begin
                bus.in_x1 = q1[k+1];
                bus.in_x2 = q2[k+1];
                bus.in_x3 = q3[k+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            wait_done(1'b0, n);
            check_eq("b2b_latency", n, 16);
            check_result("b2b", q1[k], q2[k], q3[k]);
            check_eq("b2b_in_ready", bus.in_ready, 1);
            @(posedge clk);
        end
        #1;
        check_eq("b2b_idle", bus.out_valid, 0);

        // Garbage on in_valid/in_x during RUN must be ignored
        a1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom};
        a3 = {$urandom, $urandom};
        start_txn(a1, a2, a3);
        wait_done(1'b1, n);
        check_eq("ign_latency", n, 16);
        check_result("ign", a1, a2, a3);
        @(posedge clk);
        #1;

        // Asynchronous reset at RUN cycle 7
        start_txn({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_valid", bus.out_valid, 0);
        check_eq("mid_rst_ready", bus.in_ready, 1);
        check_eq("mid_rst_y", {bus.out_y1 | bus.out_y2 | bus.out_y3}, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        hits = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) hits++;
        end
        check_eq("mid_rst_no_result", hits, 0);
        a1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom};
        a3 = {$urandom, $urandom};
        start_txn(a1, a2, a3);
        wait_done(1'b0, n);
        check_eq("post_rst_latency", n, 16);
        check_result("post_rst", a1, a2, a3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
